xadc_drp_sequencer: RTL and testbench
=====================================

XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waited in WAIT_EOC or DRP_WAIT (used only with XADC_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port control_in  in  32  control register image; [0] start request, [15:8] channel number.
REQ-005 SHALL have port eoc  in  1  XADC end-of-conversion pulse.
REQ-006 SHALL have port drdy  in  1  XADC DRP data-ready pulse.
REQ-007 SHALL have port do_in  in  16  XADC DRP read data.
REQ-008 SHALL have port den  out  1  DRP enable, one-cycle pulse.
REQ-009 SHALL have port dwe  out  1  DRP write enable, constant 0.
REQ-010 SHALL have port daddr  out  7  DRP address.
REQ-011 SHALL have port control_int  out  2  write-back to control register; [1] done, [0] start.
REQ-012 SHALL have port we_int  out  1  write strobe for control_int, one-cycle pulse.
REQ-013 SHALL have port data_out  out  32  result, {20'b0, sample[11:0]}.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port timeout_err  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT_EOC -> DRP_REQ -> DRP_WAIT -> DONE -> IDLE.
REQ-017 IDLE: on control_in[0]=1, SHALL latch control_in[14:8] as channel and go to WAIT_EOC next cycle; otherwise stay.
REQ-018 WAIT_EOC: SHALL move to DRP_REQ on the first eoc=1 sampled in WAIT_EOC; an eoc coinciding with the IDLE start cycle SHALL be ignored.
REQ-019 DRP_REQ: SHALL assert den=1 for exactly one cycle with daddr=latched channel, then go to DRP_WAIT.
REQ-020 DRP_WAIT: on drdy=1 SHALL capture do_in[15:4] into data_out[11:0] and go to DONE; drdy in any other state SHALL be ignored.
REQ-021 DONE: SHALL assert we_int=1 with control_int=2'b10 for exactly one cycle, then return to IDLE.
REQ-022 control_int SHALL be 2'b00 whenever we_int=0.
REQ-023 daddr SHALL hold the latched channel from DRP_REQ until the next start; den SHALL be 0 outside DRP_REQ.
REQ-024 data_out SHALL hold its value until overwritten by the next drdy capture.
REQ-025 Latency start-sample to we_int SHALL be: 1 (to WAIT_EOC) + eoc wait + 1 (DRP_REQ) + drdy wait + 1 (DONE) cycles.
REQ-026 control_in[0] changes while busy=1 SHALL be ignored; a start still asserted in the IDLE cycle after DONE SHALL start a new conversion.

Reset
REQ-027 On rst=1 (asynchronous) SHALL go to IDLE with den=0, dwe=0, daddr=0, control_int=0, we_int=0, data_out=0, busy=0, timeout_err=0, channel=0, timeout counter=0.
REQ-028 rst mid-transaction SHALL abort without issuing we_int; a late drdy after release SHALL be ignored.

Configuration
REQ-029 Macro XADC_SEQ_TIMEOUT_EN defined: 8-bit-or-wider counter SHALL clear on entry to WAIT_EOC and DRP_WAIT, increment each cycle in those states; on reaching TIMEOUT_CYC SHALL set timeout_err=1, leave data_out unchanged, and go to DONE.
REQ-030 timeout_err SHALL clear only on rst or on the next accepted start.
REQ-031 Macro undefined: no counter; WAIT_EOC and DRP_WAIT SHALL wait indefinitely; timeout_err SHALL be constant 0.

Structure
REQ-032 Shared package xadc_pkg SHALL hold the FSM state encoding, the control bit positions (START_BIT=0, DONE_BIT=1, CH_LSB=8, CH_MSB=15) and the default TIMEOUT_CYC.
REQ-033 Counter MAY be sub-module xadc_seq_timer; the FSM SHALL remain in xadc_drp_sequencer.

Verification
REQ-034 Start ch 0x03, eoc after 5 cycles, drdy 2 cycles after den with do_in=0xABC0 -> den once with daddr=0x03, data_out=0x00000ABC, we_int once with control_int=2'b10.
REQ-035 eoc in the same cycle as start -> ignored; second eoc 10 cycles later triggers den.
REQ-036 drdy pulsed in IDLE and WAIT_EOC -> no capture, data_out unchanged.
REQ-037 rst asserted during DRP_WAIT -> all outputs reset immediately; no we_int; later drdy ignored.
REQ-038 Macro on, TIMEOUT_CYC=16, no eoc -> after 16 cycles timeout_err=1, we_int pulse, data_out unchanged; next start clears timeout_err.
REQ-039 Start held high across DONE -> second conversion begins in the IDLE cycle after DONE.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP read sequencer: FSM state encoding,
// control-register bit positions and the default wait timeout.
package xadc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_EOC = 3'd1,
        DRP_REQ  = 3'd2,
        DRP_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int START_BIT = 0;
    localparam int DONE_BIT  = 1;
    localparam int CH_LSB    = 8;
    localparam int CH_MSB    = 15;

    // The DRP address is 7 bits wide, so bit CH_MSB of the channel field is dropped.
    localparam int CH_W      = CH_MSB - CH_LSB;
    localparam int SAMPLE_W  = 12;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/xadc_seq_timer.sv
// Wait-state cycle counter for the sequencer; expired marks the last permitted
// cycle of a wait. Only instantiated when XADC_SEQ_TIMEOUT_EN is defined.
module xadc_seq_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] count;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: on start, waits for end-of-conversion, reads the channel
// over DRP and writes 'done' back. Define XADC_SEQ_TIMEOUT_EN to build the wait timeout.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] control_in,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [1:0]  control_int,
    output logic        we_int,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        timeout_err
);

    state_t              state;
    state_t              state_next;
    logic [CH_W-1:0]     channel;
    logic [SAMPLE_W-1:0] sample;
    logic                start_accept;
    logic                capture;
    logic                timed_out;
    logic                expired;
    logic                unused_bits;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A real eoc/drdy wins over a timeout expiring in the same cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        start_accept = 1'b0;
        capture      = 1'b0;
        timed_out    = 1'b0;
        case (state)
            IDLE: begin
                if (control_in[START_BIT]) begin
                    start_accept = 1'b1;
                    state_next   = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                if (eoc) begin
                    state_next = DRP_REQ;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DRP_REQ: state_next = DRP_WAIT;
            DRP_WAIT: begin
                if (drdy) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            channel <= '0;
            sample  <= '0;
        end else begin
            if (start_accept) channel <= control_in[CH_LSB +: CH_W];
            if (capture)      sample  <= do_in[15 -: SAMPLE_W];
        end
    end

`ifdef XADC_SEQ_TIMEOUT_EN
    logic timer_run;
    logic timeout_q;

    assign timer_run = (state == WAIT_EOC) || (state == DRP_WAIT);

    xadc_seq_timer #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (start_accept) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = timed_out;
`endif

    assign den      = (state == DRP_REQ);
    assign dwe      = 1'b0;
    assign daddr    = channel;
    assign we_int   = (state == DONE);
    assign busy     = (state != IDLE);
    assign data_out = {{(32 - SAMPLE_W){1'b0}}, sample};

    always_comb begin
        control_int           = '0;
        control_int[DONE_BIT] = we_int;
    end

    assign unused_bits = ^{control_in[31:CH_MSB], control_in[CH_LSB-1:START_BIT+1],
                           do_in[15-SAMPLE_W:0]};

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_xadc_drp_sequencer;

    localparam int unsigned TIMEOUT = 16;
`ifdef XADC_SEQ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] control_in;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [1:0]  control_int;
    logic        we_int;
    logic [31:0] data_out;
    logic        busy;
    logic        timeout_err;

    xadc_drp_sequencer #(
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .control_in  (control_in),
        .eoc         (eoc),
        .drdy        (drdy),
        .do_in       (do_in),
        .den         (den),
        .dwe         (dwe),
        .daddr       (daddr),
        .control_int (control_int),
        .we_int      (we_int),
        .data_out    (data_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: which event the transaction is waiting for, what it has latched.
    logic        m_busy      = 1'b0;
    logic        m_want_eoc  = 1'b0;
    logic        m_den       = 1'b0;
    logic        m_want_drdy = 1'b0;
    logic        m_we        = 1'b0;
    logic        m_terr      = 1'b0;
    logic [6:0]  m_channel   = '0;
    logic [11:0] m_sample    = '0;
    int          m_wait      = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_want_eoc <= 1'b0; m_den <= 1'b0; m_want_drdy <= 1'b0;
            m_we <= 1'b0; m_terr <= 1'b0; m_channel <= '0; m_sample <= '0; m_wait <= 0;
        end else if (!m_busy) begin
            if (control_in[0]) begin
                m_busy <= 1'b1; m_want_eoc <= 1'b1; m_channel <= control_in[14:8];
                m_terr <= 1'b0; m_wait <= 0;
            end
        end else if (m_want_eoc) begin
            m_wait <= m_wait + 1;
            if (eoc) begin
                m_want_eoc <= 1'b0; m_den <= 1'b1;
            end else if (TMO_ON && (m_wait + 1 == int'(TIMEOUT))) begin
                m_want_eoc <= 1'b0; m_we <= 1'b1; m_terr <= 1'b1;
            end
        end else if (m_den) begin
            m_den <= 1'b0; m_want_drdy <= 1'b1; m_wait <= 0;
        end else if (m_want_drdy) begin
            m_wait <= m_wait + 1;
            if (drdy) begin
                m_want_drdy <= 1'b0; m_sample <= do_in[15:4]; m_we <= 1'b1;
            end else if (TMO_ON && (m_wait + 1 == int'(TIMEOUT))) begin
                m_want_drdy <= 1'b0; m_we <= 1'b1; m_terr <= 1'b1;
            end
        end else begin
            m_we <= 1'b0; m_busy <= 1'b0;
        end
    end

    int         den_count = 0;
    int         we_count  = 0;
    int         den_cyc   = 0;
    int         we_cyc    = 0;
    logic [6:0] den_addr  = '0;
    logic [1:0] we_ctl    = '0;

    always @(negedge clk) begin
        check("cycle_outputs",
              {den, dwe, daddr, control_int, we_int, busy, timeout_err, data_out},
              {m_den, 1'b0, m_channel, (m_we ? 2'b10 : 2'b00), m_we, m_busy, m_terr,
               20'b0, m_sample});
        if (den) begin
            den_count++; den_cyc = cyc; den_addr = daddr;
        end
        if (we_int) begin
            we_count++; we_cyc = cyc; we_ctl = control_int;
        end
    end

    // Inputs change 1 time unit after the falling edge, clear of both clock edges.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int start_cyc = 0;

    task automatic start_conv(input logic [6:0] ch, input bit hold);
        control_in       = 32'hDEAD_80FE;
        control_in[14:8] = ch;
        control_in[0]    = 1'b1;
        tick(1);
        start_cyc = cyc;
        if (!hold) control_in[0] = 1'b0;
    endtask

    task automatic pulse_eoc();
        eoc = 1'b1;
        tick(1);
        eoc = 1'b0;
    endtask

    task automatic pulse_drdy(input logic [15:0] d);
        do_in = d;
        drdy  = 1'b1;
        tick(1);
        drdy  = 1'b0;
        do_in = 16'h5A5A;
    endtask

    task automatic wait_we(input int max_cyc);
        int n = 0;
        while (!we_int && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("we_int_within_bound", we_int, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    int d0, w0;

    initial begin
        rst = 1'b1; control_in = '0; eoc = 1'b0; drdy = 1'b0; do_in = '0;
        tick(2);
        check("reset_outputs", {den, dwe, daddr, control_int, we_int, busy, timeout_err, data_out}, 64'h0);
        rst = 1'b0;
        tick(1);
        check("idle_after_reset", {den, dwe, daddr, control_int, we_int, busy, timeout_err, data_out}, 64'h0);

        // Basic read: eoc 5 cycles after start, drdy 2 cycles after den.
        d0 = den_count; w0 = we_count;
        start_conv(7'h03, 1'b0);
        tick(4);
        pulse_eoc();
        tick(2);
        pulse_drdy(16'hABC0);
        check("t1_we_int", we_int, 1);
        check("t1_control_int", control_int, 2'b10);
        check("t1_data_out", data_out, 32'h0000_0ABC);
        tick(1);
        check("t1_idle_busy", busy, 0);
        check("t1_control_int_idle", control_int, 2'b00);
        check("t1_den_count", den_count - d0, 1);
        check("t1_daddr_at_den", den_addr, 7'h03);
        check("t1_den_latency", den_cyc - start_cyc, 5);
        check("t1_we_count", we_count - w0, 1);
        check("t1_we_latency", we_cyc - start_cyc, 8);
        check("t1_we_ctl", we_ctl, 2'b10);

        // eoc coinciding with the start cycle is ignored.
        d0 = den_count; w0 = we_count;
        eoc = 1'b1;
        start_conv(7'h05, 1'b0);
        eoc = 1'b0;
        tick(9);
        check("t2_no_early_den", den_count - d0, 0);
        check("t2_still_busy", busy, 1);
        pulse_eoc();
        tick(1);
        pulse_drdy(16'h1234);
        tick(1);
        check("t2_den_latency", den_cyc - start_cyc, 10);
        check("t2_daddr_at_den", den_addr, 7'h05);
        check("t2_data_out", data_out, 32'h0000_0123);
        check("t2_we_count", we_count - w0, 1);

        // drdy outside DRP_WAIT is ignored.
        d0 = den_count;
        pulse_drdy(16'hFFF0);
        check("t3_drdy_idle_ignored", data_out, 32'h0000_0123);
        start_conv(7'h07, 1'b0);
        tick(2);
        pulse_drdy(16'h5550);
        check("t3_drdy_wait_eoc_ignored", data_out, 32'h0000_0123);
        check("t3_no_den", den_count - d0, 0);
        pulse_eoc();
        pulse_drdy(16'h7770);
        check("t3_drdy_drp_req_ignored", data_out, 32'h0000_0123);
        pulse_drdy(16'h8880);
        check("t3_capture", data_out, 32'h0000_0888);
        tick(1);

        // Reset while waiting for drdy aborts immediately; a late drdy is ignored.
        w0 = we_count;
        start_conv(7'h0A, 1'b0);
        tick(1);
        pulse_eoc();
        tick(1);
        check("t4_in_drp_wait", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_immediate", {den, dwe, daddr, control_int, we_int, busy, timeout_err, data_out}, 64'h0);
        tick(2);
        rst = 1'b0;
        pulse_drdy(16'h4440);
        tick(2);
        check("t4_late_drdy_ignored", data_out, 32'h0);
        check("t4_no_we_int", we_count - w0, 0);
        check("t4_idle", busy, 0);

        // Start held across DONE restarts in the following IDLE cycle; busy-time changes ignored.
        d0 = den_count; w0 = we_count;
        start_conv(7'h11, 1'b1);
        control_in[14:8] = 7'h12;
        tick(2);
        pulse_eoc();
        check("t5_daddr_first", den_addr, 7'h11);
        tick(1);
        pulse_drdy(16'h2220);
        check("t5_we_first", we_int, 1);
        tick(1);
        check("t5_idle_gap", busy, 0);
        tick(1);
        check("t5_restarted", busy, 1);
        check("t5_restart_gap", cyc - we_cyc, 2);
        check("t5_daddr_relatched", daddr, 7'h12);
        control_in[0] = 1'b0;
        tick(1);
        pulse_eoc();
        check("t5_daddr_second", den_addr, 7'h12);
        tick(1);
        pulse_drdy(16'h3330);
        check("t5_data_second", data_out, 32'h0000_0333);
        tick(1);
        check("t5_den_count", den_count - d0, 2);
        check("t5_we_count", we_count - w0, 2);

`ifdef XADC_SEQ_TIMEOUT_EN
        // No eoc: timeout after TIMEOUT cycles in WAIT_EOC.
        d0 = den_count;
        start_conv(7'h15, 1'b0);
        wait_we(40);
        check("t6_eoc_timeout_latency", we_cyc - start_cyc, 16);
        check("t6_timeout_err", timeout_err, 1);
        check("t6_data_unchanged", data_out, 32'h0000_0333);
        check("t6_no_den", den_count - d0, 0);
        tick(3);
        check("t6_timeout_sticky", timeout_err, 1);
        check("t6_idle", busy, 0);
        start_conv(7'h16, 1'b0);
        check("t6_cleared_by_start", timeout_err, 0);
        // No drdy: timeout after TIMEOUT cycles in DRP_WAIT.
        tick(1);
        pulse_eoc();
        wait_we(40);
        check("t6_drdy_timeout_latency", we_cyc - den_cyc, 17);
        check("t6_drdy_timeout_err", timeout_err, 1);
        check("t6_drdy_data_unchanged", data_out, 32'h0000_0333);
        tick(1);
        start_conv(7'h17, 1'b0);
        tick(1);
        pulse_eoc();
        tick(1);
        pulse_drdy(16'h6660);
        check("t6_recover_data", data_out, 32'h0000_0666);
        check("t6_recover_terr", timeout_err, 0);
        tick(1);
`else
        // Without the timeout option the wait is unbounded.
        w0 = we_count;
        start_conv(7'h15, 1'b0);
        tick(20);
        check("t6_still_waiting", busy, 1);
        check("t6_no_timeout_err", timeout_err, 0);
        check("t6_no_we_int", we_count - w0, 0);
        pulse_eoc();
        tick(1);
        pulse_drdy(16'h6660);
        check("t6_late_data", data_out, 32'h0000_0666);
        check("t6_we_int", we_int, 1);
        tick(1);
`endif

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
